// File: rtl/gray_decode_monitor_pkg.sv
// Shared definitions for the Gray-code receive monitor: default widths,
// lock state and step classification types.
package gray_decode_monitor_pkg;

   localparam int unsigned GRAY_N_DEFAULT = 8;
   localparam int unsigned ERR_W_DEFAULT  = 8;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_t;

   typedef enum logic [1:0] {
      STEP_NONE,
      STEP_UP,
      STEP_DOWN,
      STEP_ILLEGAL
   } step_kind_t;

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of the
// Gray bits at and above its position.
module gray_to_bin #(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0] gray,
   output logic [N-1:0] bin
);

   always_comb begin
      bin = '0;
      for (int unsigned i = 0; i < N; i++) begin
         bin[i] = ^(gray >> i);
      end
   end

endmodule

// File: rtl/gray_decode_monitor.sv
// Receive-side Gray bus checker: synchronises, decodes, classifies each
// accepted step as up/down and counts illegal steps (saturating).
module gray_decode_monitor
   import gray_decode_monitor_pkg::*;
#(
   parameter int unsigned N     = GRAY_N_DEFAULT,
   parameter int unsigned ERR_W = ERR_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     gray_in,
   input  logic             sample_en,
   output logic [N-1:0]     bin_out,
   output logic             valid,
   output logic             dir_up,
   output logic             step_err,
   output logic [ERR_W-1:0] err_count,
   output logic             locked
);

   logic [N-1:0] sync1;
   logic [N-1:0] sync2;
   logic [N-1:0] last_gray;
   logic [N-1:0] sync_bin;
   logic [N-1:0] delta;
   logic         accept;
   lock_state_t  state_q;
   lock_state_t  state_d;
   step_kind_t   step_kind;

   gray_to_bin #(.N(N)) u_gray_to_bin (
      .gray (sync2),
      .bin  (sync_bin)
   );

   // First sample after reset only establishes the reference; later samples
   // are accepted only when the synchronised code actually moved.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      if (sample_en) begin
         case (state_q)
            UNLOCKED: begin
               accept  = 1'b1;
               state_d = LOCKED;
            end
            LOCKED:   accept = (sync2 != last_gray);
            default:  state_d = UNLOCKED;
         endcase
      end
   end

   assign delta = sync_bin - bin_out;

   always_comb begin
      step_kind = STEP_NONE;
      if (accept && (state_q == LOCKED)) begin
         if (delta == N'(1))
            step_kind = STEP_UP;
         else if (delta == '1)
            step_kind = STEP_DOWN;
         else
            step_kind = STEP_ILLEGAL;
      end
   end

   assign locked = (state_q == LOCKED);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= UNLOCKED;
         sync1     <= '0;
         sync2     <= '0;
         last_gray <= '0;
         bin_out   <= '0;
         valid     <= 1'b0;
         dir_up    <= 1'b0;
         step_err  <= 1'b0;
         err_count <= '0;
      end else begin
         state_q  <= state_d;
         sync1    <= gray_in;
         sync2    <= sync1;
         valid    <= accept;
         step_err <= (step_kind == STEP_ILLEGAL);
         if (accept) begin
            last_gray <= sync2;
            bin_out   <= sync_bin;
         end
         case (step_kind)
            STEP_UP:      dir_up <= 1'b1;
            STEP_DOWN:    dir_up <= 1'b0;
            STEP_ILLEGAL: if (err_count != '1) err_count <= err_count + 1'b1;
            default:      ;
         endcase
      end
   end

endmodule

// File: tb/tb_gray_decode_monitor.sv
// Bench for gray_decode_monitor: directed scenarios plus randomized Gray
// traffic, checked every cycle against a table-driven behavioural model.
module tb_gray_decode_monitor;

   logic       clk;
   logic       rst;
   logic [7:0] gray_in;
   logic       sample_en;

   logic [7:0] bin_out;
   logic       valid, dir_up, step_err, locked;
   logic [7:0] err_count;

   logic [7:0] bin_out_s;
   logic       valid_s, dir_up_s, step_err_s, locked_s;
   logic [1:0] err_count_s;

   int errors = 0;
   int checks = 0;

   gray_decode_monitor #(.N(8), .ERR_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .gray_in   (gray_in),
      .sample_en (sample_en),
      .bin_out   (bin_out),
      .valid     (valid),
      .dir_up    (dir_up),
      .step_err  (step_err),
      .err_count (err_count),
      .locked    (locked)
   );

   gray_decode_monitor #(.N(8), .ERR_W(2)) dut_sat (
      .clk       (clk),
      .rst       (rst),
      .gray_in   (gray_in),
      .sample_en (sample_en),
      .bin_out   (bin_out_s),
      .valid     (valid_s),
      .dir_up    (dir_up_s),
      .step_err  (step_err_s),
      .err_count (err_count_s),
      .locked    (locked_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: inverse of the binary->Gray map, built from b ^ (b >> 1).
   logic [7:0] bin_of [256];
   logic [7:0] hist [$];
   logic       m_locked, m_valid, m_dir, m_err;
   logic [7:0] m_bin;
   int         m_cnt8, m_cnt2;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_locked = 0; m_valid = 0; m_dir = 0; m_err = 0;
      m_bin = 0; m_cnt8 = 0; m_cnt2 = 0;
      hist.delete();
      hist.push_back(8'h00);
      hist.push_back(8'h00);
   endtask

   // A code seen at edge k is visible to the accept logic at edge k+2.
   initial begin
      logic [7:0] code, nb, d;
      logic       r, se;
      logic [7:0] g;
      model_reset();
      forever begin
         @(posedge clk);
         r = rst; se = sample_en; g = gray_in;
         #1;
         if (r) begin
            model_reset();
         end else begin
            code = hist.pop_front();
            hist.push_back(g);
            m_valid = 0;
            m_err   = 0;
            nb = bin_of[code];
            if (se && (!m_locked || nb != m_bin)) begin
               if (m_locked) begin
                  d = nb - m_bin;
                  if (d == 8'd1) m_dir = 1;
                  else if (d == 8'd255) m_dir = 0;
                  else begin
                     m_err = 1;
                     if (m_cnt8 < 255) m_cnt8++;
                     if (m_cnt2 < 3) m_cnt2++;
                  end
               end
               m_locked = 1;
               m_bin    = nb;
               m_valid  = 1;
            end
         end
         checks++;
         if (bin_out !== m_bin || valid !== m_valid || dir_up !== m_dir ||
             step_err !== m_err || locked !== m_locked || err_count !== 8'(m_cnt8) ||
             err_count_s !== 2'(m_cnt2) || bin_out_s !== m_bin) begin
            errors++;
            $display("FAIL cycle_model t=%0t: bin=%0d/%0d valid=%0b/%0b dir=%0b/%0b err=%0b/%0b lock=%0b/%0b cnt=%0d/%0d cnt2=%0d/%0d (got/exp)",
                     $time, bin_out, m_bin, valid, m_valid, dir_up, m_dir, step_err, m_err,
                     locked, m_locked, err_count, m_cnt8, err_count_s, m_cnt2);
         end
      end
   end

   task automatic step(input logic [7:0] code, input int n);
      gray_in = code;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [7:0] cur;
      for (int b = 0; b < 256; b++) begin
         bin_of[8'(b) ^ (8'(b) >> 1)] = 8'(b);
      end
      chk("model_g2b_80", int'(bin_of[8'h80]), 255);
      chk("model_g2b_0F", int'(bin_of[8'h0F]), 10);
      chk("model_g2b_06", int'(bin_of[8'h06]), 4);

      rst = 1'b1; gray_in = 8'h00; sample_en = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_bin", int'(bin_out), 0);
      chk("reset_locked", int'(locked), 0);
      chk("reset_valid", int'(valid), 0);
      rst = 1'b0;

      step(8'h00, 4);
      chk("lock_locked", int'(locked), 1);
      chk("lock_bin", int'(bin_out), 0);
      step(8'h01, 4); step(8'h03, 4); step(8'h02, 4); step(8'h06, 4);
      chk("up_bin4", int'(bin_out), 4);
      chk("up_dir", int'(dir_up), 1);
      chk("up_noerr", int'(err_count), 0);
      step(8'h02, 4);
      chk("down_bin3", int'(bin_out), 3);
      chk("down_dir", int'(dir_up), 0);
      step(8'h0F, 4);
      chk("jump_bin10", int'(bin_out), 10);
      chk("jump_cnt", int'(err_count), 1);
      chk("jump_dir_held", int'(dir_up), 0);
      step(8'h00, 4); step(8'h80, 4);
      chk("wrap_down_bin", int'(bin_out), 255);
      chk("wrap_down_dir", int'(dir_up), 0);
      step(8'h00, 4);
      chk("wrap_up_bin", int'(bin_out), 0);
      chk("wrap_up_dir", int'(dir_up), 1);
      for (int unsigned j = 0; j < 5; j++) step((j % 2 == 0) ? 8'h0F : 8'h00, 4);
      chk("sat_cnt2", int'(err_count_s), 3);
      chk("sat_cnt8", int'(err_count), 7);

      sample_en = 1'b0;
      step(8'h01, 4); step(8'h03, 4);
      chk("held_bin", int'(bin_out), 10);
      sample_en = 1'b1;
      step(8'h03, 4);
      chk("pending_bin", int'(bin_out), 2);

      step(8'h00, 4); step(8'h01, 4); step(8'h03, 4); step(8'h02, 4); step(8'h06, 4);
      chk("pre_rst_bin", int'(bin_out), 4);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_bin", int'(bin_out), 0);
      chk("midrst_locked", int'(locked), 0);
      chk("midrst_cnt", int'(err_count), 0);
      rst = 1'b0;
      step(8'h06, 4);
      chk("relock_locked", int'(locked), 1);
      chk("relock_bin", int'(bin_out), 4);

      cur = 8'd4;
      for (int unsigned i = 0; i < 3000; i++) begin
         int unsigned r;
         r = $urandom_range(0, 99);
         if (r < 45)      cur = cur + 8'd1;
         else if (r < 80) cur = cur - 8'd1;
         else if (r < 90) cur = 8'($urandom_range(0, 255));
         gray_in   = cur ^ (cur >> 1);
         sample_en = ($urandom_range(0, 9) < 7);
         rst       = ($urandom_range(0, 299) == 0);
         repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      rst = 1'b0;
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
